// File: rtl/div_iter_unit.sv
// Iterative restoring divider for the RV32M DIV, DIVU, REM and REMU operations.
// The unit resolves one quotient bit per cycle with a trial subtraction, and applies
// sign correction when it enters DONE. Divide-by-zero and signed overflow skip the
// iteration and complete one cycle after the start is accepted.
//
// state | meaning
// IDLE  | waiting for i_start; outputs idle, o_result held
// CALC  | one shift/trial-subtract step per cycle, WIDTH steps in total
// DONE  | o_valid pulse for one cycle, then back to IDLE
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [1:0]       op_q;
    logic             neg_dvd;
    logic             neg_dvs;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   rem_q;
    logic [CNT_W-1:0] cnt;

    logic             signed_op;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             div_zero;
    logic             sgn_ovf;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             no_borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] final_res;
    logic             last_iter;

    // Operand conditioning at start, one restoring step, and the final sign correction.
    always_comb begin
        signed_op   = ~i_op[0];
        dvd_mag     = (signed_op && i_dividend[WIDTH-1]) ? (~i_dividend + WIDTH'(1)) : i_dividend;
        dvs_mag     = (signed_op && i_divisor[WIDTH-1])  ? (~i_divisor + WIDTH'(1))  : i_divisor;
        div_zero    = (i_divisor == '0);
        sgn_ovf     = signed_op && (i_dividend == MIN_NEG) && (i_divisor == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = i_op[1] ? i_dividend : '1;
        end else begin
            special_res = i_op[1] ? '0 : i_dividend;
        end

        // The remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} + {1'b0, ~{1'b0, div_q}} + (WIDTH+2)'(1);
        no_borrow = trial[WIDTH+1];
        rem_next  = no_borrow ? trial[WIDTH:0] : rem_shift;
        quo_next  = {quo_q[WIDTH-2:0], no_borrow};

        quo_fix   = ((op_q == 2'b00) && (neg_dvd != neg_dvs)) ? (~quo_next + WIDTH'(1)) : quo_next;
        rem_fix   = ((op_q == 2'b10) && neg_dvd) ? (~rem_next[WIDTH-1:0] + WIDTH'(1))
                                                 : rem_next[WIDTH-1:0];
        final_res = op_q[1] ? rem_fix : quo_fix;
        last_iter = (cnt == CNT_W'(WIDTH-1));
    end

    // Control FSM with registered busy/valid/result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            op_q     <= '0;
            neg_dvd  <= 1'b0;
            neg_dvs  <= 1'b0;
            div_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt      <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (i_start) begin
                        op_q    <= i_op;
                        neg_dvd <= signed_op & i_dividend[WIDTH-1];
                        neg_dvs <= signed_op & i_divisor[WIDTH-1];
                        div_q   <= dvs_mag;
                        quo_q   <= dvd_mag;
                        rem_q   <= '0;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                        if (div_zero || sgn_ovf) begin
                            o_result <= special_res;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        o_result <= final_res;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
